pe_array_stream_if: RTL



---
 rtl/pe_array_stream_if.sv | 117 +++++++++++
 1 files changed

// File: rtl/pe_array_stream_if.sv
// Streaming wrapper for the elementwise PE array: packs incoming A/B element pairs
// into wide operand vectors, captures the product vector, then streams it out.
module pe_array_stream_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ARRAY_SIZE = 128
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [DATA_WIDTH-1:0]            in_a,
   input  logic [DATA_WIDTH-1:0]            in_b,
   output logic [DATA_WIDTH*ARRAY_SIZE-1:0] pe_a,
   output logic [DATA_WIDTH*ARRAY_SIZE-1:0] pe_b,
   input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] pe_mul,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic                             out_last,
   output logic                             busy
);

   localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
   localparam int VEC_W = DATA_WIDTH * ARRAY_SIZE;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

   typedef enum logic [1:0] {
      S_LOAD    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DRAIN   = 2'd2
   } state_t;

   // Handshakes: a transfer happens on a rising clk edge where valid && ready;
   // valid/ready never depend combinationally on the other side's signal.
   state_t             state_q;
   state_t             state_d;
   logic [IDX_W-1:0]   idx_q;
   logic [VEC_W-1:0]   a_q;
   logic [VEC_W-1:0]   b_q;
   logic [VEC_W-1:0]   res_q;
   logic               in_hs;
   logic               out_hs;
   logic               at_last;

   assign in_hs   = in_valid && in_ready;
   assign out_hs  = out_valid && out_ready;
   assign at_last = (idx_q == LAST_IDX);
   assign pe_a    = a_q;
   assign pe_b    = b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:    if (in_hs && at_last) state_d = S_CAPTURE;
         S_CAPTURE: state_d = S_DRAIN;
         S_DRAIN:   if (out_hs && at_last) state_d = S_LOAD;
         default:   state_d = S_LOAD;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_LOAD);
      out_valid = (state_q == S_DRAIN);
      out_last  = (state_q == S_DRAIN) && at_last;
      busy      = (state_q != S_LOAD) || (idx_q != '0);
   end

   // Element 0 lives in the most significant slice of every packed vector.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         if (idx_q == IDX_W'(i)) begin
            out_data = res_q[(ARRAY_SIZE-i)*DATA_WIDTH-1 -: DATA_WIDTH];
         end
      end
   end

   // One index serves both the load and drain phases; they never overlap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else if (in_hs || out_hs) begin
         idx_q <= at_last ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else if (in_hs) begin
         for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (idx_q == IDX_W'(i)) begin
               a_q[(ARRAY_SIZE-i)*DATA_WIDTH-1 -: DATA_WIDTH] <= in_a;
               b_q[(ARRAY_SIZE-i)*DATA_WIDTH-1 -: DATA_WIDTH] <= in_b;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else if (state_q == S_CAPTURE) begin
         res_q <= pe_mul;
      end
   end

endmodule
